swipt_phase_gen: RTL



---
 rtl/swipt_phase_gen_if.sv | 25 ++
 rtl/swipt_phase_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/swipt_phase_gen_if.sv
// Configuration channel for swipt_phase_gen: a valid/ready offer of a new
// phase increment and duty, taken together as one transaction.
interface swipt_phase_gen_if #(
   parameter int unsigned PHASE_W = 24,
   parameter int unsigned DUTY_W  = 12
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [PHASE_W-1:0] cfg_inc;
   logic [DUTY_W-1:0]  cfg_duty;

   modport master (
      output cfg_valid,
      output cfg_inc,
      output cfg_duty,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_inc,
      input  cfg_duty,
      output cfg_ready
   );
endinterface

// File: rtl/swipt_phase_gen.sv
// NCO-based N-phase PWM generator with glitch-free config updates at period
// boundaries and heartbeat-gated drain. Define SWIPT_SOFT_START_EN for duty soft-start.
module swipt_phase_gen #(
   parameter int unsigned        N_PHASES  = 4,
   parameter int unsigned        PHASE_W   = 24,
   parameter int unsigned        DUTY_W    = 12,
   parameter logic [PHASE_W-1:0] DEF_INC   = 24'h001A37,
   parameter logic [DUTY_W-1:0]  DEF_DUTY  = 12'h800,
   parameter logic [DUTY_W-1:0]  RAMP_STEP = 12'h010
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                swipt_alive,
   swipt_phase_gen_if.slave    cfg,
   output logic [N_PHASES-1:0] swipt_out,
   output logic                period_tick,
   output logic                busy,
   output logic [1:0]          state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RAMP  = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int unsigned SHIFT = PHASE_W - $clog2(N_PHASES);

   state_t                r_state;
   logic [PHASE_W-1:0]    r_acc;
   logic [N_PHASES-1:0]   r_out;
   logic                  r_tick;
   logic                  r_pend;
   logic [PHASE_W-1:0]    r_pinc;
   logic [DUTY_W-1:0]     r_pduty;
   logic [PHASE_W-1:0]    r_inc;
   logic [DUTY_W-1:0]     r_duty;
   logic [DUTY_W-1:0]     r_duty_eff;

   logic                  w_active;
   logic [PHASE_W:0]      w_sum;
   logic                  w_wrap;
   logic                  w_accept;
   logic                  w_apply;
   logic [PHASE_W-1:0]    w_inc_nxt;
   logic [DUTY_W-1:0]     w_duty_nxt;
   logic [DUTY_W:0]       w_ramp_sum;
   logic                  w_ramp_done;
   logic [DUTY_W-1:0]     w_ramp_duty;
   logic                  w_run_req;
   logic                  w_to_idle;
   logic [PHASE_W-1:0]    w_phase;
   logic [N_PHASES-1:0]   w_cmp;

   always_comb begin
      w_active    = (r_state != S_IDLE);
      w_sum       = {1'b0, r_acc} + {1'b0, r_inc};
      w_wrap      = w_active && w_sum[PHASE_W];
      w_accept    = cfg.cfg_valid && !r_pend;
      // Pending config lands immediately in IDLE, otherwise only on a wrap edge
      w_apply     = r_pend && (!w_active || w_wrap);
      w_inc_nxt   = w_apply ? r_pinc  : r_inc;
      w_duty_nxt  = w_apply ? r_pduty : r_duty;
      w_ramp_sum  = {1'b0, r_duty_eff} + {1'b0, RAMP_STEP};
      w_ramp_done = (w_ramp_sum >= {1'b0, w_duty_nxt});
      w_ramp_duty = w_ramp_done ? w_duty_nxt : w_ramp_sum[DUTY_W-1:0];
      w_run_req   = en && swipt_alive;
      w_to_idle   = w_wrap && ((r_state == S_DRAIN) || (w_inc_nxt == '0));
      w_phase     = '0;
      w_cmp       = '0;
      for (int unsigned k = 0; k < N_PHASES; k++) begin
         w_phase  = r_acc + (PHASE_W'(k) << SHIFT);
         w_cmp[k] = (w_phase[PHASE_W-1 -: DUTY_W] < r_duty_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_acc      <= '0;
         r_out      <= '0;
         r_tick     <= 1'b0;
         r_pend     <= 1'b0;
         r_pinc     <= '0;
         r_pduty    <= '0;
         r_inc      <= DEF_INC;
         r_duty     <= DEF_DUTY;
         r_duty_eff <= '0;
      end else begin
         r_tick <= w_wrap;

         if (w_accept) begin
            r_pend  <= 1'b1;
            r_pinc  <= cfg.cfg_inc;
            r_pduty <= cfg.cfg_duty;
         end else if (w_apply) begin
            r_pend  <= 1'b0;
         end

         if (w_apply) begin
            r_inc  <= r_pinc;
            r_duty <= r_pduty;
         end

         if (r_state == S_IDLE) begin
            r_acc      <= '0;
            r_out      <= '0;
            r_duty_eff <= '0;
            if (w_run_req && (w_inc_nxt != '0)) begin
`ifdef SWIPT_SOFT_START_EN
               r_state    <= S_RAMP;
`else
               r_state    <= S_RUN;
               r_duty_eff <= w_duty_nxt;
`endif
            end
         end else if (w_to_idle) begin
            // Drain completion and a zero increment share the same clean stop
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_out      <= '0;
            r_duty_eff <= '0;
         end else begin
            r_acc <= w_sum[PHASE_W-1:0];
            r_out <= w_cmp;
            case (r_state)
               S_RAMP: begin
                  if (w_wrap) begin
                     r_duty_eff <= w_ramp_duty;
                  end
                  if (!w_run_req) begin
                     r_state <= S_DRAIN;
                  end else if (w_wrap ? w_ramp_done : (r_duty_eff == r_duty)) begin
                     r_state <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (w_wrap) begin
                     r_duty_eff <= w_duty_nxt;
                  end
                  if (!w_run_req) begin
                     r_state <= S_DRAIN;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign cfg.cfg_ready = !r_pend;
   assign swipt_out     = r_out;
   assign period_tick   = r_tick;
   assign busy          = (r_state != S_IDLE);
   assign state_o       = r_state;

endmodule
